// File: rtl/spi_master_pkg.sv
// Shared definitions for the memory-mapped SPI master: register offsets,
// CTRL/STAT bit positions and the transfer FSM states.
package spi_master_pkg;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    localparam int CTRL_IE   = 7;
    localparam int CTRL_CPOL = 6;
    localparam int CTRL_CPHA = 5;
    localparam int CTRL_SS   = 4;

    localparam int STAT_IRQ  = 7;
    localparam int STAT_BUSY = 6;
    localparam int STAT_DONE = 5;
    localparam int STAT_OVR  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: emits a one-clk tick every div_i+1 enabled clocks,
// restarting its count on load.
module spi_clk_div (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [3:0] div_i,
    output logic       tick_o
);

    logic [3:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || tick_o)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_master.sv
// CPU-facing SPI master: DATA/CTRL/STAT registers, 8-bit full-duplex shifter
// and the IDLE/SHIFT/FINISH transfer sequencer.
module spi_master
    import spi_master_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       ss_n
);

    state_t     state_q, state_d;
    logic       ie_q, cpol_q, cpha_q, ss_q;
    logic [3:0] div_q;
    logic       done_q, ovr_q;
    logic [7:0] sh_q, rx_q, dout_q, stat;
    logic [3:0] edge_q;
    logic       phase_q, mosi_q, samp_q;
    logic       busy, tick, lead, last_edge;
    logic       wr_data, rd_data, wr_ctrl, rd_stat, start;

    assign wr_data   = cs &  we & (rs == REG_DATA);
    assign rd_data   = cs & ~we & (rs == REG_DATA);
    assign wr_ctrl   = cs &  we & (rs == REG_CTRL);
    assign rd_stat   = cs & ~we & (rs == REG_CTRL);
    assign busy      = (state_q != IDLE);
    assign start     = wr_data & ~busy;
    // Edge counter is even before an odd-numbered (leading) edge.
    assign lead      = ~edge_q[0];
    assign last_edge = tick && (edge_q == 4'd15);

    assign irq  = ie_q & done_q;
    assign sclk = cpol_q ^ phase_q;
    assign mosi = mosi_q;
    assign ss_n = ss_q;
    assign dout = dout_q;

    spi_clk_div u_div (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (state_q == SHIFT),
        .load_i (start),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        stat            = 8'h00;
        stat[STAT_IRQ]  = irq;
        stat[STAT_BUSY] = busy;
        stat[STAT_DONE] = done_q;
        stat[STAT_OVR]  = ovr_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_edge) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie_q    <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            ss_q    <= 1'b1;
            div_q   <= 4'd0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            sh_q    <= 8'h00;
            rx_q    <= 8'h00;
            dout_q  <= 8'h00;
            edge_q  <= 4'd0;
            phase_q <= 1'b0;
            mosi_q  <= 1'b0;
            samp_q  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ie_q <= din[CTRL_IE];
                ss_q <= din[CTRL_SS];
                // Mode and divider are frozen for the transfer in flight.
                if (!busy) begin
                    cpol_q <= din[CTRL_CPOL];
                    cpha_q <= din[CTRL_CPHA];
                    div_q  <= din[3:0];
                end
            end

            if (start) begin
                sh_q    <= din;
                edge_q  <= 4'd0;
                phase_q <= 1'b0;
                if (!cpha_q) mosi_q <= din[7];
            end

            if (tick) begin
                phase_q <= ~phase_q;
                edge_q  <= edge_q + 4'd1;
                if (lead) begin
                    if (cpha_q) mosi_q <= sh_q[7];
                    else        samp_q <= miso;
                end else begin
                    sh_q <= {sh_q[6:0], cpha_q ? miso : samp_q};
                    // Mode 0 presents the next bit here, except after the last bit.
                    if (!cpha_q && !last_edge) mosi_q <= sh_q[6];
                end
            end

            if (state_q == FINISH) rx_q <= sh_q;

            if (state_q == FINISH)     done_q <= 1'b1;
            else if (rd_data || start) done_q <= 1'b0;

            if (wr_data && busy) ovr_q <= 1'b1;
            else if (rd_stat)    ovr_q <= 1'b0;

            if (rd_data)      dout_q <= rx_q;
            else if (rd_stat) dout_q <= stat;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CPU register accesses, loopback and slave
// model on the SPI pins, and a scoreboard of expected received bytes.
module tb_spi_master;

    logic       clk, rst, cs, we, rs, miso, loop_en, slv_miso;
    logic [7:0] din, dout;
    logic       irq, sclk, mosi, ss_n;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    spi_master dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .rs   (rs),
        .din  (din),
        .dout (dout),
        .irq  (irq),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso),
        .ss_n (ss_n)
    );

    assign miso = loop_en ? mosi : slv_miso;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Access tasks start and end on a falling clk edge.
    task automatic wr(input logic r, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; rs = r; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic r, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; rs = r;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic rd_stat_chk(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        rd(1'b1, v);
        check(tag, v, exp);
    endtask

    task automatic rd_data_chk(input string tag);
        logic [7:0] v, e;
        rd(1'b0, v);
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s observed=%0h expected=scoreboard-entry", tag, v);
        end else begin
            e = sb.pop_front();
            check(tag, v, e);
        end
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!irq && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, irq, 1'b1);
    endtask

    initial begin
        logic [63:0] wave, exp_wave;
        logic [7:0]  bits, slv_byte;
        logic        prev;
        int          cyc, rises, slv_idx;

        rst = 1'b0; cs = 1'b0; we = 1'b0; rs = 1'b0; din = 8'h00;
        loop_en = 1'b1; slv_miso = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ss_n", ss_n, 1'b1);
        check("rst_irq",  irq,  1'b0);
        check("rst_dout", dout, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rd_stat_chk("rst_stat", 8'h00);

        // Mode 0, DIV=0, loopback
        wr(1'b1, 8'h80);
        check("m0_ss_low", ss_n, 1'b0);
        sb.push_back(8'hA5);
        wr(1'b0, 8'hA5);
        cyc = 0; rises = 0; bits = 8'h00; prev = sclk;
        while (!irq && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (sclk && !prev) begin
                rises++;
                bits = {bits[6:0], mosi};
            end
            prev = sclk;
        end
        check("m0_irq_cycle", cyc, 17);
        check("m0_rises", rises, 8);
        check("m0_mosi_seq", bits, 8'hA5);
        rd_stat_chk("m0_stat", 8'hA0);
        rd_data_chk("m0_data");
        check("m0_irq_clear", irq, 1'b0);

        // Overrun: second write while busy is dropped
        sb.push_back(8'hC3);
        wr(1'b0, 8'hC3);
        wr(1'b0, 8'h11);
        rd_stat_chk("ovr_stat", 8'h50);
        rd_stat_chk("ovr_cleared", 8'h40);
        wait_irq("ovr_irq");
        rd_data_chk("ovr_data");
        rd_stat_chk("ovr_stat_idle", 8'h00);

        // Mode 3, DIV=3, slave returns 0x3C
        wr(1'b1, 8'h63);
        check("m3_sclk_idle", sclk, 1'b1);
        loop_en = 1'b0; slv_byte = 8'h3C; slv_idx = 7;
        sb.push_back(8'h3C);
        wr(1'b0, 8'h96);
        prev = sclk; wave = '0; exp_wave = '0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            wave[i-1] = sclk;
            exp_wave[i-1] = 1'b1 ^ ((i / 4) % 2 == 1);
            if (prev && !sclk && slv_idx >= 0) begin
                slv_miso = slv_byte[slv_idx];
                slv_idx--;
            end
            prev = sclk;
        end
        check("m3_sclk_wave", wave, exp_wave);
        rd_stat_chk("m3_finish_read", 8'h40);
        rd_stat_chk("m3_done", 8'h20);
        rd_data_chk("m3_data");

        // SS and CTRL while busy
        loop_en = 1'b1;
        wr(1'b1, 8'h10);
        check("ss_high", ss_n, 1'b1);
        sb.push_back(8'h5A);
        wr(1'b0, 8'h5A);
        wr(1'b1, 8'h05);
        check("ss_low_busy", ss_n, 1'b0);
        repeat (15) @(negedge clk);
        rd_stat_chk("ss_len_busy", 8'h40);
        rd_stat_chk("ss_len_done", 8'h20);
        rd_data_chk("ss_data");
        wr(1'b1, 8'h05);
        sb.push_back(8'h81);
        wr(1'b0, 8'h81);
        repeat (96) @(negedge clk);
        rd_stat_chk("div5_busy", 8'h40);
        rd_stat_chk("div5_done", 8'h20);
        rd_data_chk("div5_data");

        // Reset mid-transfer after 5 sclk edges
        wr(1'b1, 8'h80);
        wr(1'b0, 8'h3C);
        repeat (5) @(negedge clk);
        check("mid_sclk_pre", sclk, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_sclk", sclk, 1'b0);
        check("mid_mosi", mosi, 1'b0);
        check("mid_ss_n", ss_n, 1'b1);
        check("mid_irq",  irq,  1'b0);
        check("mid_dout", dout, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_stat_chk("mid_stat", 8'h00);
        begin
            logic [7:0] v;
            rd(1'b0, v);
            check("mid_rx", v, 8'h00);
        end
        wr(1'b1, 8'h80);
        sb.push_back(8'hFF);
        wr(1'b0, 8'hFF);
        wait_irq("post_rst_irq");
        rd_data_chk("post_rst_data");
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
